// File: rtl/moving_sum_avg.sv
// Boxcar moving-window sum/average: Sum += Din - Dold once the window is full,
// plain accumulation while the first WDEPTH samples fill the window.
module moving_sum_avg #(
  parameter int DSIZE  = 6,
  parameter int WDEPTH = 16,
  parameter int ASIZE  = $clog2(WDEPTH),
  parameter int SSIZE  = DSIZE + ASIZE
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [DSIZE-1:0] Din,
  input  logic [DSIZE-1:0] Dold,
  output logic [SSIZE-1:0] Sum,
  output logic [DSIZE-1:0] Avg,
  output logic             Out_valid,
  output logic             Full
);

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ASIZE-1:0] CNT_LAST = ASIZE'(WDEPTH - 1);

  state_t           state_q, state_d;
  logic [ASIZE-1:0] cnt_q, cnt_d;
  logic [SSIZE-1:0] sum_q, sum_d;
  logic [DSIZE-1:0] avg_q, avg_d;
  logic             vld_q, vld_d;
  logic             full_q, full_d;

  logic [SSIZE:0]   sum_ext, din_ext, dold_ext, acc;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      sum_q   <= '0;
      avg_q   <= '0;
      vld_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      avg_q   <= avg_d;
      vld_q   <= vld_d;
      full_q  <= full_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == FILL && En && cnt_q == CNT_LAST) state_d = RUN;
  end

  always_comb begin
    sum_ext  = {1'b0, sum_q};
    din_ext  = (SSIZE+1)'(Din);
    dold_ext = (SSIZE+1)'(Dold);
    acc      = sum_ext;
    cnt_d    = cnt_q;
    vld_d    = 1'b0;
    full_d   = full_q;
    if (En) begin
      if (state_q == FILL) begin
        // Shift-register output is stale during fill, so Dold is not subtracted.
        acc   = sum_ext + din_ext;
        cnt_d = cnt_q + ASIZE'(1);
        if (cnt_q == CNT_LAST) begin
          vld_d  = 1'b1;
          full_d = 1'b1;
        end
      end else begin
        acc   = sum_ext + din_ext - dold_ext;
        vld_d = 1'b1;
      end
    end
    sum_d = acc[SSIZE-1:0];
    avg_d = sum_d[SSIZE-1:ASIZE];
  end

  assign Sum       = sum_q;
  assign Avg       = avg_q;
  assign Out_valid = vld_q;
  assign Full      = full_q;

endmodule

// File: tb/tb_moving_sum_avg.sv
// Directed bench: a WDEPTH=4 instance for the hand-computed cases and a
// WDEPTH=16 instance fed through a behavioural delay line against a window model.
module tb_moving_sum_avg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WDEPTH=4 instance
  logic       a_rst, a_en;
  logic [5:0] a_din, a_dold;
  logic [7:0] a_sum;
  logic [5:0] a_avg;
  logic       a_ov, a_full;

  moving_sum_avg #(.DSIZE(6), .WDEPTH(4)) dut_a (
    .clk(clk), .Reset(a_rst), .En(a_en), .Din(a_din), .Dold(a_dold),
    .Sum(a_sum), .Avg(a_avg), .Out_valid(a_ov), .Full(a_full)
  );

  // WDEPTH=16 instance
  logic       b_rst, b_en;
  logic [5:0] b_din, b_dold;
  logic [9:0] b_sum;
  logic [5:0] b_avg;
  logic       b_ov, b_full;

  moving_sum_avg #(.DSIZE(6), .WDEPTH(16)) dut_b (
    .clk(clk), .Reset(b_rst), .En(b_en), .Din(b_din), .Dold(b_dold),
    .Sum(b_sum), .Avg(b_avg), .Out_valid(b_ov), .Full(b_full)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc_a(input logic r, input logic e, input int d, input int o);
    a_rst  = r;
    a_en   = e;
    a_din  = 6'(d);
    a_dold = 6'(o);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int s, input int a, input int v, input int f);
    chk({tag, ".sum"},  32'(a_sum),  32'(s));
    chk({tag, ".avg"},  32'(a_avg),  32'(a));
    chk({tag, ".ov"},   32'(a_ov),   32'(v));
    chk({tag, ".full"}, 32'(a_full), 32'(f));
  endtask

  initial begin
    int en_pat[7];
    int s_pat[7];
    int win[$];
    int nacc, esum;
    logic en;
    int d, o;

    a_rst = 1'b1; a_en = 1'b0; a_din = '0; a_dold = '0;
    b_rst = 1'b1; b_en = 1'b0; b_din = '0; b_dold = '0;

    // 1: reset then ramp
    for (int i = 0; i < 3; i++) cyc_a(1, 0, 0, 0);
    chk_a("t1.reset", 0, 0, 0, 0);
    for (int n = 1; n <= 8; n++) begin
      cyc_a(0, 1, n, (n > 4) ? n - 4 : 0);
      if (n < 4)       chk_a($sformatf("t1.fill%0d", n), n * (n + 1) / 2, (n * (n + 1) / 2) / 4, 0, 0);
      else if (n == 4) chk_a("t1.first", 10, 2, 1, 1);
      else             chk_a($sformatf("t1.run%0d", n), 14 + 4 * (n - 5), (14 + 4 * (n - 5)) / 4, 1, 1);
    end

    // 2: constant full-scale input, no wrap
    cyc_a(1, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc_a(0, 1, 63, (k > 4) ? 63 : 0);
      esum = ((k < 4) ? k : 4) * 63;
      chk_a($sformatf("t2.s%0d", k), esum, esum / 4, (k >= 4) ? 1 : 0, (k >= 4) ? 1 : 0);
    end

    // 3: partial fill, reset, fresh fill
    cyc_a(1, 0, 0, 0);
    cyc_a(0, 1, 5, 0);
    cyc_a(0, 1, 5, 0);
    chk_a("t3.pre", 10, 2, 0, 0);
    cyc_a(1, 0, 0, 0);
    chk_a("t3.reset", 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc_a(0, 1, 7, 0);
      chk_a($sformatf("t3.s%0d", k), 7 * k, (7 * k) / 4, (k == 4) ? 1 : 0, (k == 4) ? 1 : 0);
    end

    // 4: gapped enables, Full on 4th accepted sample
    cyc_a(1, 0, 0, 0);
    en_pat = '{1, 0, 0, 1, 0, 1, 1};
    s_pat  = '{2, 2, 2, 4, 4, 6, 8};
    for (int i = 0; i < 7; i++) begin
      cyc_a(0, en_pat[i] != 0, 2, 0);
      chk_a($sformatf("t4.c%0d", i), s_pat[i], s_pat[i] / 4, (i == 6) ? 1 : 0, (i == 6) ? 1 : 0);
    end
    cyc_a(0, 0, 2, 2);
    chk_a("t4.hold", 8, 2, 0, 1);
    cyc_a(0, 1, 2, 2);
    chk_a("t4.run", 8, 2, 1, 1);

    // 5: reset wins over En while in RUN
    cyc_a(1, 1, 9, 2);
    chk_a("t5.rst_en", 0, 0, 0, 0);
    cyc_a(0, 1, 3, 9);
    chk_a("t5.refill", 3, 0, 0, 0);
    cyc_a(0, 0, 0, 0);

    // 6: WDEPTH=16 with a delay line standing in for the shift register
    b_rst = 1'b1;
    @(posedge clk); #1;
    chk("t6.reset.sum", 32'(b_sum), 0);
    chk("t6.reset.full", 32'(b_full), 0);
    nacc = 0;
    for (int i = 0; i < 60; i++) begin
      en = (i % 7) != 6;
      d  = (50 + nacc) % 64;
      o  = (win.size() == 16) ? win[0] : 0;
      b_rst  = 1'b0;
      b_en   = en;
      b_din  = 6'(d);
      b_dold = 6'(o);
      @(posedge clk); #1;
      if (en) begin
        win.push_back(d);
        if (win.size() > 16) void'(win.pop_front());
        nacc++;
      end
      esum = 0;
      foreach (win[j]) esum += win[j];
      chk($sformatf("t6.c%0d.sum", i),  32'(b_sum),  32'(esum));
      chk($sformatf("t6.c%0d.avg", i),  32'(b_avg),  32'(esum / 16));
      chk($sformatf("t6.c%0d.ov", i),   32'(b_ov),   32'((en && nacc >= 16) ? 1 : 0));
      chk($sformatf("t6.c%0d.full", i), 32'(b_full), 32'((nacc >= 16) ? 1 : 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
